sim_run_ctrl: RTL and testbench

Parametrised run controller for the pipelined MIPS core (umips_top) in simulation and FPGA bring-up. It replaces fixed-delay reset and stop-time scripting with clocked behaviour:
- generates the core reset for a programmable number of cycles;
- counts cycles and retired instructions;
- detects program completion through a "tohost" store, or a timeout;
- reports done/pass/fail with an exit code.

It sits beside the core top and snoops the data-memory write port and the writeback-stage retire signals.

---
 rtl/sim_run_ctrl_pkg.sv | 22 ++
 rtl/sim_run_ctrl_if.sv | 17 +
 rtl/sim_run_ctrl_sat_counter.sv | 22 ++
 rtl/sim_run_ctrl.sv | 151 +++++++++++++++
 tb/tb_sim_run_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/sim_run_ctrl_pkg.sv
// Shared types and default constants for the simulation run controller.
package sim_run_ctrl_pkg;

  // Run-controller phases: core held in reset, program running,
  // pipeline draining after the tohost store, and finished.
  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_00FC;
  localparam int          PASS_CODE_DEF   = 1;

  // Default width of the cycle and retire counters.
  localparam int CNT_W_DEF = 32;
  // Width of the shared HOLD/DRAIN phase counter, so RESET_CYCLES and
  // DRAIN_CYCLES must stay below 2**PHASE_W.
  localparam int PHASE_W   = 16;

endpackage

// File: rtl/sim_run_ctrl_if.sv
// Snoop bundle between the core and the run controller: writeback-stage
// retire signals and the data-memory write port.
interface sim_run_ctrl_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
);
  logic              retire_valid;
  logic [PC_W-1:0]   retire_pc;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // The core (or a bench standing in for it) drives the bundle.
  modport master (output retire_valid, retire_pc, mem_we, mem_addr, mem_wdata);
  // The run controller only observes it.
  modport slave  (input  retire_valid, retire_pc, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/sim_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  // Count enabled cycles, holding at the maximum instead of wrapping.
  // NOTE: sequential state is updated with <= so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller for umips_top bring-up: holds the core in reset for
// RESET_CYCLES, counts cycles and retirements, ends the run on a tohost
// store (plus a pipeline drain) or a cycle timeout, and reports the result.
// Optional build macro SIM_RUN_CTRL_HALT_LOOP_EN adds detection of a PC
// self-loop as a passing halt.
module sim_run_ctrl
  import sim_run_ctrl_pkg::*;
#(
  parameter int                PC_W           = 32,
  parameter int                DATA_W         = 32,
  parameter int                CNT_W          = CNT_W_DEF,
  parameter int                RESET_CYCLES   = 2,
  parameter int                TIMEOUT_CYCLES = 50,
  parameter int                DRAIN_CYCLES   = 4,
  parameter logic [DATA_W-1:0] TOHOST_ADDR    = DATA_W'(TOHOST_ADDR_DEF),
  parameter logic [DATA_W-1:0] PASS_CODE      = DATA_W'(PASS_CODE_DEF),
  parameter int                LOOP_CYCLES    = 8
) (
  input  logic              clk,
  input  logic              reset,
  sim_run_ctrl_if.slave     bus,
  output logic              core_reset,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [DATA_W-1:0] exit_code,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic              halted
);

  localparam logic [PHASE_W-1:0] HOLD_LAST    = PHASE_W'(RESET_CYCLES - 1);
  localparam logic [PHASE_W-1:0] DRAIN_LAST   = PHASE_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // With no drain budget the run ends on the very cycle of the hit.
  localparam state_e             AFTER_HIT    = (DRAIN_CYCLES == 0) ? DONE : DRAIN;

  state_e              state, state_d;
  logic [PHASE_W-1:0]  phase_cnt, phase_cnt_d;
  logic [DATA_W-1:0]   exit_code_d;
  logic                timeout_d, halted_d;
  logic                tohost_hit, loop_hit, counting;

  assign tohost_hit = bus.mem_we && (bus.mem_addr == TOHOST_ADDR);
  assign counting   = (state == RUN) || (state == DRAIN);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .clr (!reset),
    .en  (counting),
    .q   (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk (clk),
    .clr (!reset),
    .en  (counting && bus.retire_valid),
    .q   (retire_cnt)
  );

`ifdef SIM_RUN_CTRL_HALT_LOOP_EN
  // Length of the current run of retirements at one PC; 0 until the
  // first retirement of the run phase.
  logic [PC_W-1:0]  last_pc;
  logic [CNT_W-1:0] run_len, run_len_d;

  assign run_len_d = ((run_len != '0) && (bus.retire_pc == last_pc)) ?
                     run_len + CNT_W'(1) : CNT_W'(1);
  assign loop_hit  = (state == RUN) && bus.retire_valid &&
                     (run_len_d == CNT_W'(LOOP_CYCLES));

  // Track the last retired PC and how many times in a row it retired.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_pc <= '0;
      run_len <= '0;
    end else if ((state == RUN) && bus.retire_valid) begin
      last_pc <= bus.retire_pc;
      run_len <= run_len_d;
    end
  end
`else
  // Without the loop detector the retire PC and loop length are not used.
  logic unused_loop;
  assign unused_loop = ^{bus.retire_pc, 32'(LOOP_CYCLES)};
  assign loop_hit    = 1'b0;
`endif

  // Next-state and next-result logic for the run phases.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state;
    phase_cnt_d = '0;
    exit_code_d = exit_code;
    timeout_d   = timeout;
    halted_d    = halted;
    unique case (state)
      HOLD: begin
        if (phase_cnt == HOLD_LAST) state_d = RUN;
        else                        phase_cnt_d = phase_cnt + PHASE_W'(1);
      end
      RUN: begin
        if (tohost_hit) begin
          exit_code_d = bus.mem_wdata;
          state_d     = AFTER_HIT;
        end else if (loop_hit) begin
          halted_d    = 1'b1;
          exit_code_d = PASS_CODE;
          state_d     = AFTER_HIT;
        end else if (cycle_cnt == TIMEOUT_LAST) begin
          timeout_d   = 1'b1;
          state_d     = DONE;
        end
      end
      DRAIN: begin
        if (phase_cnt == DRAIN_LAST) state_d = DONE;
        else                         phase_cnt_d = phase_cnt + PHASE_W'(1);
      end
      DONE: ;
    endcase
  end

  // State and registered status outputs; results are derived from the
  // next state so done/pass/fail rise together on the entry edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= HOLD;
      phase_cnt  <= '0;
      core_reset <= 1'b1;
      exit_code  <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_d;
      phase_cnt  <= phase_cnt_d;
      core_reset <= !((state_d == RUN) || (state_d == DRAIN));
      exit_code  <= exit_code_d;
      done       <= (state_d == DONE);
      pass       <= (state_d == DONE) && (exit_code_d == PASS_CODE);
      fail       <= (state_d == DONE) && (exit_code_d != PASS_CODE);
      timeout    <= timeout_d;
      halted     <= halted_d;
    end
  end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl with default parameters
// (RESET_CYCLES=2, TIMEOUT_CYCLES=50, DRAIN_CYCLES=4, tohost at 0xFC).
// Loop-halt scenarios are included when SIM_RUN_CTRL_HALT_LOOP_EN is set.
module tb_sim_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_reset;
  logic [31:0] cycle_cnt, retire_cnt, exit_code;
  logic        done, pass, fail, timeout, halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sim_run_ctrl_if #(.PC_W(32), .DATA_W(32)) bus ();

  sim_run_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .core_reset (core_reset),
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt),
    .exit_code  (exit_code),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .halted     (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one RUN-phase cycle from a negedge and return at the next negedge.
  task automatic run_cycle(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic rv, input logic [31:0] pc);
    bus.mem_we       = we;
    bus.mem_addr     = addr;
    bus.mem_wdata    = data;
    bus.retire_valid = rv;
    bus.retire_pc    = pc;
    @(negedge clk);
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.retire_valid = 1'b0;
    bus.retire_pc    = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Two reset cycles, release, then walk through HOLD; returns at the
  // negedge that begins the first RUN cycle (cycle_cnt == 0).
  task automatic release_reset(input string tag);
    reset = 1'b0;
    @(negedge clk);
    check({tag, "_rst_core_reset"}, core_reset, 1);
    check({tag, "_rst_cycle_cnt"},  cycle_cnt,  0);
    check({tag, "_rst_retire_cnt"}, retire_cnt, 0);
    check({tag, "_rst_status"}, {exit_code[27:0], done, pass, fail, timeout},
          {28'h0, 4'b0000});
    check({tag, "_rst_halted"}, halted, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check({tag, "_hold1_core_reset"}, core_reset, 1);
    @(negedge clk);
    check({tag, "_run_core_reset"}, core_reset, 0);
    check({tag, "_run_cycle_cnt0"}, cycle_cnt, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.retire_valid = 1'b0;
    bus.retire_pc    = '0;
    @(negedge clk);

    // Pass after 10 RUN cycles plus 4 drain cycles; near-miss stores ignored.
    release_reset("pass");
    run_cycle(1'b0, 32'h0,  32'h0, 1'b1, 32'h100);   // cnt 0
    run_cycle(1'b0, 32'h0,  32'h0, 1'b0, 32'h0);     // cnt 1
    run_cycle(1'b0, 32'h0,  32'h0, 1'b1, 32'h104);   // cnt 2
    run_cycle(1'b1, 32'hF8, 32'h1, 1'b0, 32'h0);     // cnt 3: wrong address
    run_cycle(1'b0, 32'h0,  32'h0, 1'b0, 32'h0);     // cnt 4
    run_cycle(1'b0, 32'hFC, 32'h1, 1'b1, 32'h108);   // cnt 5: no write enable
    idle(3);                                         // cnt 6..8
    check("pass_not_done_early", done, 0);
    run_cycle(1'b1, 32'hFC, 32'h1, 1'b0, 32'h0);     // cnt 9: tohost
    check("pass_drain_exit_code", exit_code, 1);
    check("pass_drain_core_reset", core_reset, 0);
    idle(3);
    check("pass_drain_not_done", done, 0);
    idle(1);
    check("pass_done", done, 1);
    check("pass_pass", pass, 1);
    check("pass_fail", fail, 0);
    check("pass_timeout", timeout, 0);
    check("pass_cycle_cnt", cycle_cnt, 14);
    check("pass_retire_cnt", retire_cnt, 3);
    check("pass_done_core_reset", core_reset, 1);
    idle(3);
    check("pass_frozen_cycle_cnt", cycle_cnt, 14);
    check("pass_halted", halted, 0);

    // First tohost write wins; a later write during DRAIN is ignored.
    release_reset("first");
    run_cycle(1'b1, 32'hFC, 32'hDEAD, 1'b0, 32'h0);
    run_cycle(1'b1, 32'hFC, 32'h1,    1'b0, 32'h0);
    idle(3);
    check("first_done", done, 1);
    check("first_exit_code", exit_code, 32'hDEAD);
    check("first_fail", fail, 1);
    check("first_pass", pass, 0);
    check("first_cycle_cnt", cycle_cnt, 5);

    // Timeout on the 50th RUN cycle.
    release_reset("tmo");
    idle(49);
    check("tmo_not_yet", {done, timeout}, 2'b00);
    idle(1);
    check("tmo_timeout", timeout, 1);
    check("tmo_done", done, 1);
    check("tmo_fail", fail, 1);
    check("tmo_exit_code", exit_code, 0);
    check("tmo_cycle_cnt", cycle_cnt, 50);
    check("tmo_core_reset", core_reset, 1);

    // A tohost store on that same cycle beats the timeout.
    release_reset("tmohit");
    idle(49);
    run_cycle(1'b1, 32'hFC, 32'h1, 1'b0, 32'h0);
    check("tmohit_timeout", timeout, 0);
    check("tmohit_exit_code", exit_code, 1);
    check("tmohit_not_done", done, 0);
    idle(4);
    check("tmohit_pass", {done, pass, fail, timeout}, 4'b1100);
    check("tmohit_cycle_cnt", cycle_cnt, 54);

    // Reset in the middle of a run restarts cleanly.
    release_reset("mid");
    for (int i = 0; i < 20; i++) run_cycle(1'b0, 32'h0, 32'h0, i[0], 32'h200 + 4 * i);
    check("mid_cycle_cnt", cycle_cnt, 20);
    check("mid_retire_cnt", retire_cnt, 10);
    release_reset("mid2");
    for (int i = 0; i < 12; i++) run_cycle(1'b0, 32'h0, 32'h0, (i % 4) != 3, 32'h300 + 4 * i);
    check("mid2_retire_cnt", retire_cnt, 9);
    check("mid2_cycle_cnt", cycle_cnt, 12);
    check("mid2_status", {done, pass, fail, timeout, halted}, 5'b00000);

`ifdef SIM_RUN_CTRL_HALT_LOOP_EN
    // Eight consecutive retirements at 0x40 halt the run as a pass.
    release_reset("loop");
    for (int i = 0; i < 7; i++) run_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
    check("loop_not_yet", halted, 0);
    run_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
    check("loop_halted", halted, 1);
    check("loop_exit_code", exit_code, 1);
    idle(4);
    check("loop_done_pass", {done, pass, fail}, 3'b110);

    // A different PC at the 7th retirement breaks the run.
    release_reset("noloop");
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
    run_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h44);
    run_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
    idle(4);
    check("noloop_halted", halted, 0);
    check("noloop_done", done, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
